io_flag_unit: RTL and testbench

Peripheral-side I/O interface for the basic computer. Sits upstream of INPR/FGI and downstream of OUTR/FGO.
- Input path: buffers bytes from an external source in a small FIFO and presents one byte at a time to INPR, with the FGI flag.
- Output path: takes the byte written by an OUT instruction, drains it to an external sink over a valid/ready handshake, and reports completion through FGO.
- Also generates the interrupt request from IEN and the two flags.

---
 rtl/io_flag_unit.sv | 127 ++++++++++++
 tb/tb_io_flag_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_flag_unit.sv
// Peripheral I/O unit: input byte FIFO feeding INPR/FGI, OUTR drain FSM with FGO, and IRQ.
// Optional loopback of the output byte into the input FIFO under `IO_LOOPBACK_EN.
module io_flag_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           inpr_data,
  output logic                        fgi,
  input  logic                        inp_ack,
  input  logic [DATA_W-1:0]           outr_data,
  input  logic                        out_strobe,
  output logic                        fgo,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        ien,
  output logic                        irq,
  output logic                        out_overrun,
`ifdef IO_LOOPBACK_EN
  input  logic                        loopback_sel,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SEND} out_st_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_inpr, r_out_data;
  logic              r_fgi, r_fgo, r_out_valid, r_irq, r_overrun;
  out_st_t           r_state;

  logic              w_lb, w_full, w_lb_push, w_push, w_pop, w_done;
  logic [DATA_W-1:0] w_push_data;

`ifdef IO_LOOPBACK_EN
  assign w_lb = loopback_sel;
`else
  assign w_lb = 1'b0;
`endif

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign in_ready    = !w_full && !w_lb;
  // In loopback the pending output byte takes the FIFO write port instead of the sink.
  assign w_lb_push   = w_lb && (r_state == S_SEND) && !w_full;
  assign w_push      = (in_valid && in_ready) || w_lb_push;
  assign w_push_data = w_lb ? r_out_data : in_data;
  assign w_pop       = !r_fgi && (r_count != '0);
  assign w_done      = (r_state == S_SEND) && (w_lb ? !w_full : out_ready);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_inpr   <= '0;
      r_fgi    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_inpr   <= r_mem[r_rd_ptr];
        r_fgi    <= 1'b1;
      end else if (inp_ack && r_fgi) begin
        r_fgi    <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_irq <= ien && (r_fgi || r_fgo);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_data  <= '0;
      r_fgo       <= 1'b1;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (out_strobe) begin
            r_out_data  <= outr_data;
            r_fgo       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          // A strobe while busy is dropped, even on the completing edge.
          if (out_strobe) r_overrun <= 1'b1;
          if (w_done) begin
            r_fgo       <= 1'b1;
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inpr_data   = r_inpr;
  assign fgi         = r_fgi;
  assign fgo         = r_fgo;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid && !w_lb;
  assign irq         = r_irq;
  assign out_overrun = r_overrun;
  assign fifo_count  = r_count;
endmodule

// File: tb/tb_io_flag_unit.sv
// Scoreboard bench for io_flag_unit: expected bytes queued at stimulus, checked at INPR / sink.
module tb_io_flag_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] inpr_data;
  logic       fgi;
  logic       inp_ack = 1'b0;
  logic [7:0] outr_data = '0;
  logic       out_strobe = 1'b0;
  logic       fgo;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       ien = 1'b0;
  logic       irq;
  logic       out_overrun;
  logic [2:0] fifo_count;
`ifdef IO_LOOPBACK_EN
  logic       loopback_sel = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];

  io_flag_unit #(.FIFO_DEPTH(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inpr_data(inpr_data), .fgi(fgi), .inp_ack(inp_ack),
    .outr_data(outr_data), .out_strobe(out_strobe), .fgo(fgo),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ien(ien), .irq(irq), .out_overrun(out_overrun),
`ifdef IO_LOOPBACK_EN
    .loopback_sel(loopback_sel),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fgi(input int max, output int n);
    n = 0;
    while (!fgi && n < max) begin
      tick();
      n++;
    end
  endtask

  // Consume one INPR byte: compare against scoreboard, ack, check flag clears and data holds.
  task automatic drain_one(input string tag, input int exp_lat);
    int n;
    logic [7:0] exp;
    wait_fgi(8, n);
    total++;
    if (!fgi) begin
      bad++; $display("FAIL %s timeout: fgi=%0b required 1", tag, fgi);
      return;
    end
    if (exp_lat >= 0) begin
      total++;
      if (n !== exp_lat) begin bad++; $display("FAIL %s latency: got %0d required %0d", tag, n, exp_lat); end
    end
    exp = in_q.pop_front();
    total++;
    if (inpr_data !== exp) begin bad++; $display("FAIL %s data: got %h required %h", tag, inpr_data, exp); end
    inp_ack = 1'b1; tick(); inp_ack = 1'b0;
    total++;
    if (fgi !== 1'b0 || inpr_data !== exp) begin
      bad++; $display("FAIL %s ack: fgi=%0b data=%h required 0 %h", tag, fgi, inpr_data, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    total++;
    if (fgi !== 0 || fgo !== 1 || in_ready !== 1 || out_valid !== 0 || fifo_count !== 0 ||
        irq !== 0 || out_overrun !== 0 || inpr_data !== 0 || out_data !== 0) begin
      bad++; $display("FAIL reset_state: fgi=%0b fgo=%0b rdy=%0b ov=%0b cnt=%0d irq=%0b orun=%0b required 0 1 1 0 0 0 0",
                      fgi, fgo, in_ready, out_valid, fifo_count, irq, out_overrun);
    end
    reset = 1'b0; ien = 1'b1; tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL reset_irq: got %0b required 1", irq); end
    ien = 1'b0; tick();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_off: got %0b required 0", irq); end
  endtask

  task automatic test_input();
    in_valid = 1'b1; in_data = 8'h41; in_q.push_back(8'h41); tick();
    total++;
    if (fgi !== 0 || fifo_count !== 1) begin bad++; $display("FAIL push1: fgi=%0b cnt=%0d required 0 1", fgi, fifo_count); end
    in_data = 8'h42; in_q.push_back(8'h42); tick();
    total++;
    if (fgi !== 1) begin bad++; $display("FAIL first_latency: fgi=%0b required 1", fgi); end
    in_data = 8'h43; in_q.push_back(8'h43); tick();
    in_valid = 1'b0;
    total++;
    if (fifo_count !== 2) begin bad++; $display("FAIL count_after_burst: got %0d required 2", fifo_count); end
    drain_one("in0", 0);
    drain_one("in1", 1);
    drain_one("in2", 1);
    total++;
    if (fifo_count !== 0) begin bad++; $display("FAIL input_empty: got %0d required 0", fifo_count); end
  endtask

  task automatic test_full();
    int acc = 0;
    in_valid = 1'b1; in_data = 8'h10; in_q.push_back(8'h10); tick(); in_valid = 1'b0; tick();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(k);
      total++;
      if (in_ready !== (acc < 4)) begin bad++; $display("FAIL full_ready%0d: got %0b required %0b", k, in_ready, acc < 4); end
      if (acc < 4) begin in_q.push_back(in_data); acc++; end
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (fifo_count !== 4 || in_ready !== 0) begin
      bad++; $display("FAIL full_count: cnt=%0d rdy=%0b required 4 0", fifo_count, in_ready);
    end
    drain_one("full0", 0);
    for (int k = 1; k < 5; k++) drain_one("fullN", 1);
    tick(); tick();
    total++;
    if (fgi !== 0 || fifo_count !== 0) begin bad++; $display("FAIL full_no_extra: fgi=%0b cnt=%0d required 0 0", fgi, fifo_count); end
  endtask

  task automatic test_output();
    ien = 1'b1;
    outr_data = 8'h5A; out_strobe = 1'b1; out_q.push_back(8'h5A); tick(); out_strobe = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1 || out_data !== 8'h5A || fgo !== 0) begin
        bad++; $display("FAIL send_hold%0d: ov=%0b data=%h fgo=%0b required 1 5a 0", k, out_valid, out_data, fgo);
      end
      if (k >= 1) begin
        total++;
        if (irq !== 0) begin bad++; $display("FAIL irq_busy: got %0b required 0", irq); end
      end
      tick();
    end
    outr_data = 8'h33; out_strobe = 1'b1; tick(); out_strobe = 1'b0;
    total++;
    if (out_data !== 8'h5A || out_overrun !== 1) begin
      bad++; $display("FAIL overrun: data=%h orun=%0b required 5a 1", out_data, out_overrun);
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid && out_ready) begin
      logic [7:0] exp;
      exp = out_q.pop_front();
      total++;
      if (out_data !== exp) begin bad++; $display("FAIL sink_data: got %h required %h", out_data, exp); end
    end
    tick(); out_ready = 1'b0;
    total++;
    if (out_valid !== 0 || fgo !== 1 || out_overrun !== 1 || out_q.size() != 0) begin
      bad++; $display("FAIL send_done: ov=%0b fgo=%0b orun=%0b pend=%0d required 0 1 1 0", out_valid, fgo, out_overrun, out_q.size());
    end
    tick();
    total++;
    if (irq !== 1) begin bad++; $display("FAIL irq_fgo: got %0b required 1", irq); end
    ien = 1'b0;
  endtask

  task automatic test_reset_midsend();
    outr_data = 8'h99; out_strobe = 1'b1; tick(); out_strobe = 1'b0;
    total++;
    if (out_valid !== 1 || out_data !== 8'h99) begin bad++; $display("FAIL midsend_start: ov=%0b data=%h required 1 99", out_valid, out_data); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (out_valid !== 0 || fgo !== 1 || out_overrun !== 0 || out_data !== 0) begin
      bad++; $display("FAIL midsend_reset: ov=%0b fgo=%0b orun=%0b data=%h required 0 1 0 00", out_valid, fgo, out_overrun, out_data);
    end
  endtask

  task automatic test_back_to_back();
    outr_data = 8'h11; out_strobe = 1'b1; tick();
    outr_data = 8'h22; out_ready = 1'b1; tick();
    out_strobe = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 0 || fgo !== 1 || out_overrun !== 1 || out_data !== 8'h11) begin
      bad++; $display("FAIL strobe_on_done: ov=%0b fgo=%0b orun=%0b data=%h required 0 1 1 11", out_valid, fgo, out_overrun, out_data);
    end
    tick();
    total++;
    if (out_valid !== 0 || fgo !== 1) begin bad++; $display("FAIL no_second_capture: ov=%0b fgo=%0b required 0 1", out_valid, fgo); end
  endtask

`ifdef IO_LOOPBACK_EN
  task automatic test_loopback();
    int seen_valid = 0;
    loopback_sel = 1'b1; #1;
    total++;
    if (in_ready !== 0) begin bad++; $display("FAIL lb_in_ready: got %0b required 0", in_ready); end
    in_valid = 1'b1; in_data = 8'h55;
    outr_data = 8'h7E; out_strobe = 1'b1; in_q.push_back(8'h7E); tick(); out_strobe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) seen_valid++;
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (seen_valid != 0 || fgo !== 1) begin bad++; $display("FAIL lb_flags: ov_cycles=%0d fgo=%0b required 0 1", seen_valid, fgo); end
    drain_one("lb", -1);
    tick(); tick();
    total++;
    if (fgi !== 0 || fifo_count !== 0) begin bad++; $display("FAIL lb_blocked: fgi=%0b cnt=%0d required 0 0", fgi, fifo_count); end
    loopback_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_input();
    test_full();
    test_output();
    test_reset_midsend();
    test_back_to_back();
`ifdef IO_LOOPBACK_EN
    test_loopback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
